shift_sequencer: RTL and testbench



---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_stage.sv | 61 ++++++
 rtl/shift_sequencer.sv | 147 ++++++++++++++
 tb/tb_shift_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the multi-cycle logarithmic shifter:
//   - datapath width and derived stage count
//   - operation encodings carried on the 2-bit op field
//   - controller state encoding
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int WIDTH  = 32;
    localparam int STAGES = $clog2(WIDTH);   // 16/8/4/2/1 -> 5 stages
    localparam int IDX_W  = 3;               // wide enough to hold STAGES-1

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;  // reserved: operand passes through

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One stage of a logarithmic shifter. Shifts acc by 2^idx when en is set,
// otherwise passes acc through unchanged. The controller reuses a single
// instance every cycle, stepping idx from the largest stage down to stage 0.
//
// Ports:
//   acc      in  [WIDTH-1:0]  value to shift
//   idx      in  [IDX_W-1:0]  stage number (shift distance is 2^idx)
//   en       in               stage enable (the matching shift-amount bit)
//   op       in  [1:0]        OP_SLL / OP_SRL / OP_SRA / OP_RSVD
//   sign     in               fill bit for SRA (captured from original operand)
//   shifted  out [WIDTH-1:0]  stage result
// -----------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] acc,
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted
);

    localparam int NSLOT = 2 ** IDX_W;

    // Candidate results for every idx value. Slots beyond the real stages
    // pass through so that an out-of-range idx can never corrupt the data.
    logic [WIDTH-1:0] sll_c [NSLOT];
    logic [WIDTH-1:0] srl_c [NSLOT];
    logic [WIDTH-1:0] sra_c [NSLOT];

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < STAGES) begin : g_real
                localparam int SH = 1 << gi;
                assign sll_c[gi] = {acc[WIDTH-1-SH:0], {SH{1'b0}}};
                assign srl_c[gi] = {{SH{1'b0}}, acc[WIDTH-1:SH]};
                assign sra_c[gi] = {{SH{sign}}, acc[WIDTH-1:SH]};
            end else begin : g_pass
                assign sll_c[gi] = acc;
                assign srl_c[gi] = acc;
                assign sra_c[gi] = acc;
            end
        end
    endgenerate

    always_comb begin
        shifted = acc;
        if (en) begin
            case (op)
                OP_SLL:  shifted = sll_c[idx];
                OP_SRL:  shifted = srl_c[idx];
                OP_SRA:  shifted = sra_c[idx];
                default: shifted = acc;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle controller for a 32-bit logarithmic shifter. A request is taken
// over the in_valid/in_ready handshake, the 16/8/4/2/1 stages are applied one
// per clock through a single shift_stage instance, and the result is held on
// z until the consumer takes it over out_valid/out_ready.
//
// Ports:
//   clk        in         rising-edge clock
//   rst_n      in         asynchronous active-low reset
//   in_valid   in         request valid
//   in_ready   out        request can be accepted (IDLE only)
//   op         in  [1:0]  00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   x          in  [31:0] operand
//   shamt      in  [4:0]  shift amount
//   out_valid  out        result valid (DONE only)
//   out_ready  in         consumer accepts result
//   z          out [31:0] result, stable while out_valid is high
//   busy       out        high in SHIFT or DONE
//
// Build option:
//   SHIFT_SEQ_EARLY_EXIT_EN  when defined, SHIFT ends as soon as the remaining
//                            lower shift-amount bits are all zero. Results are
//                            identical; only latency changes.
//
// All outputs come straight from registers; nothing combinational runs from
// an input port to an output port.
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             busy
);

    state_e           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [4:0]       amt_reg;
    logic [1:0]       op_q_reg;
    logic             sign_q_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] z_reg;

    logic [WIDTH-1:0] stage_out;
    logic             stage_en;
    logic             last_stage;

    // Shift-amount bit for the current stage; zero when idx is past the top.
    assign stage_en = |(amt_reg & (5'd1 << idx_reg));

    shift_stage u_stage (
        .acc     (acc_reg),
        .idx     (idx_reg),
        .en      (stage_en),
        .op      (op_q_reg),
        .sign    (sign_q_reg),
        .shifted (stage_out)
    );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    // Stop once no lower stage has work left. For idx==0 the mask is empty,
    // so the final stage always terminates the sequence.
    logic [4:0] low_mask;
    assign low_mask   = (5'd1 << idx_reg) - 5'd1;
    assign last_stage = ((amt_reg & low_mask) == 5'd0);
`else
    assign last_stage = (idx_reg == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            amt_reg       <= '0;
            op_q_reg      <= '0;
            sign_q_reg    <= 1'b0;
            idx_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            z_reg         <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        acc_reg      <= x;
                        amt_reg      <= shamt;
                        op_q_reg     <= op;
                        // SRA fill comes from the original operand only,
                        // never from the partially shifted accumulator.
                        sign_q_reg   <= x[WIDTH-1];
                        idx_reg      <= IDX_W'(STAGES - 1);
                        state_reg    <= ST_SHIFT;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    acc_reg <= stage_out;
                    if (last_stage) begin
                        state_reg     <= ST_DONE;
                        out_valid_reg <= 1'b1;
                        z_reg         <= stage_out;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end

                ST_DONE: begin
                    // z_reg is untouched here, so it holds under backpressure.
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign z         = z_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed and random stimulus for shift_sequencer. Expected results come from
// a behavioural reference (native SV shift operators) and are queued when a
// request is driven, then popped when the result handshake occurs.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_s;
    logic [31:0] x_s;
    logic [4:0]  shamt_s;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] sb [$];

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_s),
        .x         (x_s),
        .shamt     (shamt_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v,
                                              input logic [4:0] s);
        case (o)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            2'b10:   return 32'($signed(v) >>> s);
            default: return v;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] s);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        int low;
        low = 4;
        for (int b = 3; b >= 0; b--)
            if (s[b]) low = b;
        return 5 - low;
`else
        return (s == s) ? 5 : 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request; bp > 0 holds out_ready low for bp cycles in DONE
    // while throwing ignored requests at the block.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                          input logic [4:0] s, input int bp);
        int cnt;
        logic [31:0] e;
        @(negedge clk);
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        out_ready = (bp == 0);
        op_s = o; x_s = v; shamt_s = s; in_valid = 1'b1;
        sb.push_back(ref_shift(o, v, s));
        @(posedge clk);               // accept edge T
        #1 in_valid = 1'b0;
        x_s = $urandom;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            chk({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
            chk({tag, " busy"}, 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, " latency"}, 32'(cnt), 32'(exp_lat(s)));
        chk({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        for (int i = 0; i < bp; i++) begin
            chk({tag, " bp_out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " bp_z"}, z, e);
            chk({tag, " bp_in_ready"}, 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            op_s = 2'b00; x_s = $urandom; shamt_s = 5'd1;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " z"}, z, e);
        $display("op=%0d x=0x%08h shamt=%0d -> z=0x%08h lat=%0d", o, v, s, z, cnt);
        @(posedge clk);               // result handshake
        #1;
        chk({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op_s = 2'b00; x_s = '0; shamt_s = '0;
        #23;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset z", z, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sra_neg4",   2'b10, 32'h8000_0000, 5'd4,  0);
        chk("sra_neg4 value", z, 32'hF800_0000);
        run_op("srl_31",     2'b01, 32'h8000_0000, 5'd31, 0);
        chk("srl_31 value", z, 32'h0000_0001);
        run_op("sll_31",     2'b00, 32'h0000_0001, 5'd31, 0);
        chk("sll_31 value", z, 32'h8000_0000);
        run_op("sra_pos31",  2'b10, 32'h7FFF_FFFF, 5'd31, 0);
        chk("sra_pos31 value", z, 32'h0000_0000);
        run_op("sra_neg31",  2'b10, 32'h8000_0001, 5'd31, 0);
        chk("sra_neg31 value", z, 32'hFFFF_FFFF);
        run_op("sra_0",      2'b10, 32'hDEAD_BEEF, 5'd0,  0);
        chk("sra_0 value", z, 32'hDEAD_BEEF);
        run_op("rsvd_7",     2'b11, 32'h1234_5678, 5'd7,  0);
        chk("rsvd_7 value", z, 32'h1234_5678);
        run_op("sll_16",     2'b00, 32'h0000_ABCD, 5'd16, 0);
        chk("sll_16 value", z, 32'hABCD_0000);
        run_op("srl_3",      2'b01, 32'hF000_0000, 5'd3,  0);
        chk("srl_3 value", z, 32'h1E00_0000);
        run_op("sra_bp",     2'b10, 32'hC000_0000, 5'd9,  10);
        chk("sra_bp value", z, 32'hFFE0_0000);
        repeat (3) begin
            @(posedge clk);
            #1 chk("bp no spurious op", 32'(busy), 32'd0);
        end

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        op_s = 2'b00; x_s = 32'h0000_00FF; shamt_s = 5'd5; in_valid = 1'b1;
        @(posedge clk);               // T
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);    // T+3
        #2 rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset z", z, 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        chk("midreset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset", 2'b01, 32'hFFFF_0000, 5'd8, 0);
        chk("post_reset value", z, 32'h00FF_FF00);

        for (int i = 0; i < 1500; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 0);
        end

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
